w_tile_replay: RTL and testbench

Reader-side controller for the weight FIFO. It pops one tile of `TILE_LEN` weights from the weight FIFO over a valid/ready handshake and stores the tile locally. It then replays the stored tile `cfg_reuse` times to the PE-array weight port, so each weight fetched from memory is reused across output passes without refetching.

---
 rtl/w_pkg.sv | 16 +
 rtl/w_tile_buf.sv | 32 +++
 rtl/w_tile_replay.sv | 110 +++++++++++
 tb/tb_w_tile_replay.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/w_pkg.sv
// Shared types and helpers for the weight tile replay controller.
package w_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } w_replay_state_e;

  localparam int W_DATA_WIDTH = 16;

  // Index width that still yields one bit for a single-entry tile.
  function automatic int w_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/w_tile_buf.sv
// Tile storage: TILE_LEN words with async clear, one write port and a
// combinational read mux.
module w_tile_buf
  import w_pkg::*;
#(
  parameter int DATA_WIDTH = W_DATA_WIDTH,
  parameter int TILE_LEN   = 8,
  parameter int AW         = w_idx_w(TILE_LEN)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [TILE_LEN-1:0][DATA_WIDTH-1:0] mem;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < TILE_LEN; i++)
        if (we && waddr == AW'(i)) mem[i] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/w_tile_replay.sv
// Weight FIFO reader: fills one tile, then replays it reuse_q times toward
// the PE array. No prefetch of the next tile while replaying.
module w_tile_replay
  import w_pkg::*;
#(
  parameter int DATA_WIDTH = W_DATA_WIDTH,
  parameter int TILE_LEN   = 8,
  parameter int REUSE_W    = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [REUSE_W-1:0]    cfg_reuse,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_tile_done,
  output logic                  busy
);

  localparam int               AW   = w_idx_w(TILE_LEN);
  localparam logic [AW-1:0]    LAST = AW'(TILE_LEN - 1);
  localparam logic [REUSE_W-1:0] ONE = REUSE_W'(1);

  w_replay_state_e         state_q, state_d;
  logic [AW-1:0]           wr_idx, rd_idx;
  logic [REUSE_W-1:0]      pass_q, reuse_q;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    in_hs, out_hs;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  w_tile_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .TILE_LEN  (TILE_LEN),
    .AW        (AW)
  ) u_buf (
    .clk  (clk),
    .rstn (rstn),
    .we   (in_hs),
    .waddr(wr_idx),
    .wdata(in_data),
    .raddr(rd_idx),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= FILL;
    else       state_q <= state_d;
  end

  // Outputs depend only on registered state, never on in_valid/out_ready.
  always_comb begin
    state_d       = state_q;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    out_last      = 1'b0;
    out_tile_done = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && wr_idx == LAST) state_d = REPLAY;
      end
      REPLAY: begin
        out_valid     = 1'b1;
        out_data      = rdata;
        out_last      = (rd_idx == LAST);
        out_tile_done = (rd_idx == LAST) && (pass_q == reuse_q - ONE);
        if (out_ready && out_tile_done) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_idx  <= '0;
      rd_idx  <= '0;
      pass_q  <= '0;
      reuse_q <= ONE;
    end else begin
      if (in_hs) begin
        if (wr_idx == '0) reuse_q <= (cfg_reuse == '0) ? ONE : cfg_reuse;
        if (wr_idx == LAST) begin
          wr_idx <= '0;
          rd_idx <= '0;
          pass_q <= '0;
        end else begin
          wr_idx <= wr_idx + AW'(1);
        end
      end
      if (out_hs) begin
        if (rd_idx == LAST) begin
          rd_idx <= '0;
          pass_q <= out_tile_done ? '0 : pass_q + ONE;
        end else begin
          rd_idx <= rd_idx + AW'(1);
        end
      end
    end
  end

  assign busy = (state_q == REPLAY) || (wr_idx != '0);

endmodule

// File: tb/tb_w_tile_replay.sv
// Scoreboard bench for w_tile_replay with TILE_LEN=4: stimulus queues the
// expected replay stream, a negedge monitor checks every output handshake.
module tb_w_tile_replay;

  localparam int DW = 16;
  localparam int TL = 4;
  localparam int RW = 8;

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
    logic          done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [RW-1:0] cfg_reuse = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_tile_done;
  logic          busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cyc = -100;
  exp_t q[$];

  w_tile_replay #(.DATA_WIDTH(DW), .TILE_LEN(TL), .REUSE_W(RW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cfg_reuse    (cfg_reuse),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_tile_done(out_tile_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every output handshake, verify stall stability.
  initial begin
    logic          stall_prev;
    logic          idle_next;
    logic [DW-1:0] sd;
    logic          sl, sdn;
    exp_t          e;
    stall_prev = 1'b0;
    idle_next  = 1'b0;
    sd = '0; sl = 1'b0; sdn = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall_prev = 1'b0;
        idle_next  = 1'b0;
      end else begin
        if (idle_next) begin
          chk("after_done_in_ready", {31'd0, in_ready}, 32'd1);
          chk("after_done_out_valid", {31'd0, out_valid}, 32'd0);
          idle_next = 1'b0;
        end
        if (stall_prev) begin
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_data", {16'd0, out_data}, {16'd0, sd});
          chk("stall_last", {31'd0, out_last}, {31'd0, sl});
          chk("stall_done", {31'd0, out_tile_done}, {31'd0, sdn});
        end
        stall_prev = 1'b0;
        if (out_valid) begin
          chk("replay_in_ready", {31'd0, in_ready}, 32'd0);
          if (out_ready) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_out: got %0h expected no word", out_data);
            end else begin
              e = q.pop_front();
              chk("out_data", {16'd0, out_data}, {16'd0, e.d});
              chk("out_last", {31'd0, out_last}, {31'd0, e.last});
              chk("out_tile_done", {31'd0, out_tile_done}, {31'd0, e.done});
            end
            if (out_tile_done) begin
              idle_next = 1'b1;
              done_cyc  = cyc;
            end
          end else begin
            stall_prev = 1'b1;
            sd  = out_data;
            sl  = out_last;
            sdn = out_tile_done;
          end
        end
      end
    end
  end

  // Queue the expected replay, then push the four words; reuse_after is
  // driven on cfg_reuse after the first word to prove it is ignored.
  task automatic feed_tile(input logic [DW-1:0] w0, w1, w2, w3,
                           input int reuse, input int reuse_after,
                           input int gap, input bit drop, output int first_cyc);
    logic [DW-1:0] w[TL];
    int eff;
    int n;
    exp_t e;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    eff = (reuse == 0) ? 1 : reuse;
    first_cyc = -1;
    for (int p = 0; p < eff; p++)
      for (int i = 0; i < TL; i++) begin
        e.d    = w[i];
        e.last = (i == TL - 1);
        e.done = (i == TL - 1) && (p == eff - 1);
        q.push_back(e);
      end
    for (int i = 0; i < TL; i++) begin
      in_valid  = 1'b1;
      in_data   = w[i];
      cfg_reuse = RW'((i == 0) ? reuse : reuse_after);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!in_ready && n < 300);
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got 0 expected 1 within 300 cycles");
      end
      if (i == 0) first_cyc = cyc;
      @(posedge clk);
      #1;
      if (i == 0) chk("busy_fill", {31'd0, busy}, 32'd1);
      if (i == TL - 1) begin
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
        chk("latency_in_ready", {31'd0, in_ready}, 32'd0);
      end else if (gap > 0) begin
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    if (drop) in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    out_ready = 1'b1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d words left expected 0", q.size());
      q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int c1, c2;
    #2 rstn = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_tile_done", {31'd0, out_tile_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Basic replay, two passes
    out_ready = 1'b1;
    feed_tile(16'h11, 16'h22, 16'h33, 16'h44, 2, 2, 0, 1, c1);
    drain(1'b0);

    // Zero reuse counts as one pass
    feed_tile(16'hA0, 16'hA1, 16'hA2, 16'hA3, 0, 0, 0, 1, c1);
    drain(1'b0);

    // Random output backpressure, three passes
    out_ready = 1'b0;
    feed_tile(16'hB0, 16'hB1, 16'hB2, 16'hB3, 3, 3, 0, 1, c1);
    drain(1'b1);

    // Input gaps with cfg_reuse changed 2->5 mid-tile
    feed_tile(16'hC0, 16'hC1, 16'hC2, 16'hC3, 2, 5, 2, 1, c1);
    drain(1'b0);

    // Reset in pass 1 at rd_idx=2, between clock edges
    out_ready = 1'b0;
    feed_tile(16'h51, 16'h52, 16'h53, 16'h54, 2, 2, 0, 1, c1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 out_ready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_data", {16'd0, out_data}, 32'd0);
    q.delete();
    @(posedge clk);
    #1 rstn = 1'b1;
    out_ready = 1'b1;
    feed_tile(16'h01, 16'h02, 16'h03, 16'h04, 1, 1, 0, 1, c1);
    drain(1'b0);

    // Back-to-back tiles, in_valid held high
    feed_tile(16'hD0, 16'hD1, 16'hD2, 16'hD3, 2, 2, 0, 0, c1);
    feed_tile(16'hE0, 16'hE1, 16'hE2, 16'hE3, 3, 3, 0, 1, c2);
    chk("b2b_accept_cycle", 32'(c2), 32'(done_cyc + 1));
    drain(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
